// File: rtl/store_packer_if.sv
// Store request/response bundle between EX/MEM, the store packer and data memory.
// The slave side is the packer; the master side is the pipeline/memory model.
interface store_packer_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_data;
    logic [1:0]        in_size;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_wdata;
    logic [3:0]        out_be;
    logic              err_valid;
    logic [ADDR_W-1:0] err_addr;

    modport slave (
        input  in_valid, in_addr, in_data, in_size, out_ready,
        output in_ready, out_valid, out_addr, out_wdata, out_be, err_valid, err_addr
    );

    modport master (
        output in_valid, in_addr, in_data, in_size, out_ready,
        input  in_ready, out_valid, out_addr, out_wdata, out_be, err_valid, err_addr
    );
endinterface

// File: rtl/store_packer.sv
// MEM-stage store formatter: replicates store data across byte lanes, builds byte
// enables, rejects misaligned/reserved sizes and queues legal stores in a small FIFO.
module store_packer #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    store_packer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam int NUM_LANES = 4;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              err_valid_q, err_valid_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [31:0]       wdata_mem [DEPTH];
    logic [3:0]        be_mem    [DEPTH];

    logic [1:0]                    ofs;
    logic                          legal, accept, push, pop, head_vld;
    logic [NUM_LANES-1:0][7:0]     pk_data;
    logic [NUM_LANES-1:0]          pk_be;

    assign ofs = bus.in_addr[1:0];

    // Each lane picks its source byte by access size; halfwords alternate low/high byte.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam logic [1:0] K = 2'(k);
        assign pk_data[k] = (bus.in_size == 2'b00) ? bus.in_data[7:0] :
                            (bus.in_size == 2'b01) ? bus.in_data[8*(k%2) +: 8] :
                                                     bus.in_data[8*k +: 8];
        assign pk_be[k]   = (bus.in_size == 2'b00) ? (ofs == K) :
                            (bus.in_size == 2'b01) ? (ofs[1] == K[1]) : 1'b1;
    end

    always_comb begin
        legal = 1'b0;
        case (bus.in_size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~ofs[0];
            2'b10:   legal = (ofs == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign head_vld     = (count_q != '0);
    assign bus.in_ready = (count_q < DEPTH_C);
    assign accept       = bus.in_valid && bus.in_ready && !flush;
    assign push         = accept && legal;
    assign pop          = head_vld && bus.out_ready;

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_valid_d = accept && !legal;
        err_addr_d  = (accept && !legal) ? bus.in_addr : err_addr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Payload storage needs no reset: it is only visible while count_q is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q]  <= {bus.in_addr[ADDR_W-1:2], 2'b00};
            wdata_mem[wr_ptr_q] <= pk_data;
            be_mem[wr_ptr_q]    <= pk_be;
        end
    end

    assign bus.out_valid = head_vld;
    assign bus.out_addr  = head_vld ? addr_mem[rd_ptr_q]  : '0;
    assign bus.out_wdata = head_vld ? wdata_mem[rd_ptr_q] : '0;
    assign bus.out_be    = head_vld ? be_mem[rd_ptr_q]    : '0;
    assign bus.err_valid = err_valid_q;
    assign bus.err_addr  = err_addr_q;
endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer: packing, errors, backpressure, wrap, flush, reset.
module tb_store_packer;
    logic clk, rst, flush;
    int   errors = 0;
    int   checks = 0;

    store_packer_if #(.ADDR_W(32)) bus ();

    store_packer #(.DEPTH(2), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.in_size   = 2'b00;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        bus.in_size  = s;
    endtask

    // Advance one rising edge; returns at the following falling edge for sampling.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if ({bus.out_addr, bus.out_wdata, bus.out_be} !== 68'h0) begin errors++; $display("FAIL reset_out_bus got=%h/%h/%h exp=0", bus.out_addr, bus.out_wdata, bus.out_be); end
        checks++; if ({bus.err_valid, bus.err_addr} !== 33'h0) begin errors++; $display("FAIL reset_err got=%b/%h exp=0/0", bus.err_valid, bus.err_addr); end
        @(negedge clk);
        rst = 1'b1;
        cycle();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_byte();
        drive(32'h1003, 32'hAABBCCDD, 2'b00);
        cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL byte_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_addr !== 32'h1000) begin errors++; $display("FAIL byte_addr got=%h exp=00001000", bus.out_addr); end
        checks++; if (bus.out_wdata !== 32'hDDDDDDDD) begin errors++; $display("FAIL byte_wdata got=%h exp=dddddddd", bus.out_wdata); end
        checks++; if (bus.out_be !== 4'b1000) begin errors++; $display("FAIL byte_be got=%b exp=1000", bus.out_be); end
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        checks++; if ({bus.out_valid, bus.out_be} !== 5'b0) begin errors++; $display("FAIL byte_drain got=%b/%b exp=0/0000", bus.out_valid, bus.out_be); end
    endtask

    task automatic test_half();
        drive(32'h2002, 32'h12345678, 2'b01);
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL half_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_addr !== 32'h2000) begin errors++; $display("FAIL half_addr got=%h exp=00002000", bus.out_addr); end
        checks++; if (bus.out_wdata !== 32'h56785678) begin errors++; $display("FAIL half_wdata got=%h exp=56785678", bus.out_wdata); end
        checks++; if (bus.out_be !== 4'b1100) begin errors++; $display("FAIL half_be got=%b exp=1100", bus.out_be); end
        cycle();
        bus.out_ready = 1'b0;
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL half_popped got=%b/%b exp=0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_err();
        drive(32'h3001, 32'hCAFEF00D, 2'b10);
        cycle();
        bus.in_valid = 1'b0;
        checks++; if ({bus.err_valid, bus.err_addr} !== {1'b1, 32'h3001}) begin errors++; $display("FAIL err1 got=%b/%h exp=1/00003001", bus.err_valid, bus.err_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL err1_no_push got=%b exp=0", bus.out_valid); end
        cycle();
        checks++; if ({bus.err_valid, bus.err_addr} !== {1'b0, 32'h3001}) begin errors++; $display("FAIL err1_pulse got=%b/%h exp=0/00003001", bus.err_valid, bus.err_addr); end
        drive(32'h4000, 32'h0, 2'b11);
        cycle();
        bus.in_valid = 1'b0;
        checks++; if ({bus.err_valid, bus.err_addr} !== {1'b1, 32'h4000}) begin errors++; $display("FAIL err2 got=%b/%h exp=1/00004000", bus.err_valid, bus.err_addr); end
        cycle();
        checks++; if ({bus.err_valid, bus.err_addr, bus.out_valid} !== {1'b0, 32'h4000, 1'b0}) begin errors++; $display("FAIL err2_hold got=%b/%h/%b exp=0/00004000/0", bus.err_valid, bus.err_addr, bus.out_valid); end
    endtask

    task automatic test_backpressure();
        drive(32'h10, 32'h11111111, 2'b10);
        cycle();
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b11) begin errors++; $display("FAIL bp_first got=%b/%b exp=1/1", bus.out_valid, bus.in_ready); end
        drive(32'h14, 32'h22222222, 2'b10);
        cycle();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%b exp=0", bus.in_ready); end
        drive(32'h18, 32'h33333333, 2'b10);
        cycle();
        checks++; if ({bus.in_ready, bus.out_addr, bus.out_wdata} !== {1'b0, 32'h10, 32'h11111111}) begin errors++; $display("FAIL bp_stable got=%b/%h/%h exp=0/00000010/11111111", bus.in_ready, bus.out_addr, bus.out_wdata); end
        bus.out_ready = 1'b1;
        cycle();
        checks++; if ({bus.out_valid, bus.in_ready, bus.out_addr} !== {2'b11, 32'h14}) begin errors++; $display("FAIL bp_pop1 got=%b/%b/%h exp=1/1/00000014", bus.out_valid, bus.in_ready, bus.out_addr); end
        cycle();
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, bus.out_addr, bus.out_wdata} !== {1'b1, 32'h18, 32'h33333333}) begin errors++; $display("FAIL bp_wrap got=%b/%h/%h exp=1/00000018/33333333", bus.out_valid, bus.out_addr, bus.out_wdata); end
        cycle();
        bus.out_ready = 1'b0;
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL bp_drained got=%b/%b exp=0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        drive(32'h101, 32'h000000EF, 2'b00);
        cycle();
        checks++; if ({bus.out_wdata, bus.out_be} !== {32'hEFEFEFEF, 4'b0010}) begin errors++; $display("FAIL b2b_first got=%h/%b exp=efefefef/0010", bus.out_wdata, bus.out_be); end
        drive(32'h200, 32'h0000BEEF, 2'b01);
        bus.out_ready = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, bus.in_ready, bus.out_addr} !== {2'b11, 32'h200}) begin errors++; $display("FAIL b2b_count got=%b/%b/%h exp=1/1/00000200", bus.out_valid, bus.in_ready, bus.out_addr); end
        checks++; if ({bus.out_wdata, bus.out_be} !== {32'hBEEFBEEF, 4'b0011}) begin errors++; $display("FAIL b2b_head got=%h/%b exp=beefbeef/0011", bus.out_wdata, bus.out_be); end
        cycle();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_flush();
        drive(32'h500, 32'h55555555, 2'b10);
        cycle();
        drive(32'h504, 32'h66666666, 2'b10);
        cycle();
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL flush_pre got=%b/%b exp=1/0", bus.out_valid, bus.in_ready); end
        drive(32'h601, 32'h77777777, 2'b10);
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        cycle();
        idle_inputs();
        checks++; if ({bus.out_valid, bus.err_valid, bus.in_ready} !== 3'b001) begin errors++; $display("FAIL flush got=%b/%b/%b exp=0/0/1", bus.out_valid, bus.err_valid, bus.in_ready); end
        checks++; if (bus.err_addr !== 32'h4000) begin errors++; $display("FAIL flush_err_addr got=%h exp=00004000", bus.err_addr); end
        drive(32'h700, 32'h88888888, 2'b10);
        cycle();
        bus.in_valid = 1'b0;
        checks++; if ({bus.out_valid, bus.out_addr} !== {1'b1, 32'h700}) begin errors++; $display("FAIL flush_after got=%b/%h exp=1/00000700", bus.out_valid, bus.out_addr); end
    endtask

    task automatic test_reset_mid();
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({bus.out_valid, bus.out_addr, bus.out_wdata, bus.out_be} !== 69'h0) begin errors++; $display("FAIL rst_mid_out got=%b/%h/%h/%b exp=0", bus.out_valid, bus.out_addr, bus.out_wdata, bus.out_be); end
        checks++; if ({bus.err_valid, bus.err_addr} !== 33'h0) begin errors++; $display("FAIL rst_mid_err got=%b/%h exp=0/0", bus.err_valid, bus.err_addr); end
        @(negedge clk);
        rst = 1'b1;
        cycle();
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL rst_mid_after got=%b/%b exp=0/1", bus.out_valid, bus.in_ready); end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_half();
        test_err();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
